// File: rtl/toggle_cover_collector_if.sv
// Cover-index stream from the toggle collector to the host link.
// master drives index/valid, slave returns ready.
interface toggle_cover_collector_if #(
  parameter int unsigned IDX_W = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;

  modport master (
    output out_valid,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/toggle_cover_collector.sv
// Sticky toggle-cover bitmap; each first-time hit becomes one
// global cover index on a valid/ready stream, lowest bit first.
module toggle_cover_collector #(
  parameter int unsigned WIDTH       = 62,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned IDX_W       = 32,
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     valid,
  input  logic                 enable,
  input  logic                 clear,
  toggle_cover_collector_if.master out_if,
  output logic [CW-1:0]        cover_count,
  output logic                 all_covered,
  output logic                 idle
);

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] hit_new;
  logic [WIDTH-1:0] sel_mask;
  logic [IW-1:0]    sel_idx;
  logic [CW-1:0]    pop;
  logic             found;
  logic             load;

  assign load = !out_if.out_valid || out_if.out_ready;

  always_comb begin
    hit_new = '0;
    if (enable && !clear)
      hit_new = valid & ~covered;
    pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pop = pop + CW'(hit_new[i]);
  end

  // Candidates come from registered pending only, so bits
  // arriving this cycle wait for the next load.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i] && !found) begin
        found       = 1'b1;
        sel_idx     = IW'(i);
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      covered          <= '0;
      pending          <= '0;
      cover_count      <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_index <= '0;
    end else if (clear) begin
      covered          <= '0;
      pending          <= '0;
      cover_count      <= '0;
      out_if.out_valid <= 1'b0;
    end else begin
      if (enable)
        covered <= covered | valid;
      cover_count <= cover_count + pop;
      pending <= (pending & ~(load ? sel_mask : '0))
               | hit_new;
      if (load) begin
        out_if.out_valid <= found;
        if (found)
          out_if.out_index <= IDX_W'(COVER_INDEX)
                            + IDX_W'(sel_idx);
      end
    end
  end

  assign all_covered = (cover_count == CW'(WIDTH));
  assign idle        = !(|pending) && !out_if.out_valid;

endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
Synthesizable receiving end for per-bit toggle cover events. A coverage group drives a WIDTH-bit one-hot-per-point hit vector each cycle into this block. The block keeps a sticky covered bitmap and turns each first-time hit into exactly one global cover index. Indices stream out on a valid/ready port to the FPGA/fuzzer host link, with a running distinct-coverage count and a per-iteration clear.

Parameters:
WIDTH, 62, number of toggle cover points in this group (1..256)
COVER_INDEX, 0, global index of bit 0 of this group
IDX_W, 32, width of emitted global cover index

Ports:
clock  input  1  sole clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
valid  input  WIDTH  per-point hit vector, bit i = point COVER_INDEX+i hit this cycle
enable  input  1  1 = sample valid this cycle; 0 = ignore valid
clear  input  1  single-cycle pulse, starts a new coverage iteration
out_valid  output  1  out_index holds a newly covered point
out_ready  input  1  host accepts out_index
out_index  output  IDX_W  global cover index COVER_INDEX+i
cover_count  output  $clog2(WIDTH+1)  distinct points covered since reset/clear
all_covered  output  1  cover_count == WIDTH
idle  output  1  no pending points and out_valid == 0

Behaviour:
- Reset (reset_n low, asynchronous): covered = 0, pending = 0, out_valid = 0, out_index = 0, cover_count = 0, all_covered = 0, idle = 1.
- Sampling (enable = 1, clear = 0):
  - new = valid & ~covered.
  - covered |= valid; pending |= new; cover_count += popcount(new).
  - A point repeatedly hit is reported only once per iteration.
- enable = 0: valid is ignored entirely; the output stream still drains.
- Output register:
  - Loads when out_valid == 0, or when out_valid && out_ready (slot freed this cycle).
  - Load picks the lowest set pending bit i, sets out_index = COVER_INDEX + i (zero-extended, modulo 2^IDX_W) and out_valid = 1, and clears pending[i] in the same edge.
  - If pending is empty at load time, out_valid goes 0 and out_index holds its last value.
- Handshake: while out_valid && !out_ready, out_index and out_valid stay stable. Sustained throughput is 1 index/cycle with out_ready held high.
- Latency: a hit on bit i sampled at edge N sets pending at N. out_valid with index i is visible after edge N+1 if the slot is free and i is the lowest pending bit.
- Simultaneous events:
  - New hits and an output load in the same cycle do not conflict. A loaded bit is already covered, so it never re-enters pending.
  - New bits landing in the load cycle are not candidates for that load; they become candidates from the next edge.
  - Multiple new bits in one cycle are emitted in ascending index order.
- clear = 1 (synchronous, priority over everything except reset):
  - Next edge: covered = 0, pending = 0, cover_count = 0, out_valid = 0.
  - Any unaccepted index is discarded even if out_ready = 1 that cycle.
  - valid in the clear cycle is ignored; sampling resumes the following cycle.
- all_covered and idle are combinational from registered state.
- cover_count never exceeds WIDTH, since covered is sticky; no saturation logic is needed.
- Reset asserted mid-stream: all state drops immediately to reset values; no partial index is emitted after release.

Test Plan:
- Reset check: hold reset_n = 0 with valid all-ones → out_valid = 0, cover_count = 0, idle = 1. Release → still idle until enable = 1.
- Single hit, COVER_INDEX = 100: valid = bit 5 for 3 consecutive cycles, out_ready = 1 → exactly one transfer of out_index = 105; cover_count = 1.
- Burst ordering: valid = bits {3, 0, 61} in one cycle, out_ready = 1 → out_index 100, 103, 161 on consecutive cycles; cover_count = 3; idle returns to 1 after the third transfer.
- Backpressure: hold out_ready = 0 for 5 cycles after bit 7 is hit → out_valid = 1 and out_index = 107 stay stable. Bit 2 hit meanwhile → 107 is emitted first, then 102.
- Clear mid-stream: 4 points pending, out_valid = 1; pulse clear with out_ready = 1 and valid = bit 9 → next cycle out_valid = 0, cover_count = 0, bit 9 not covered. Re-hit bit 9 → 109 is emitted.
- Full coverage: drive valid all-ones once → cover_count = 62, all_covered = 1, 62 transfers of 100..161 in order. Assert reset_n low at transfer 30 → outputs go to reset values immediately.
